heartbeat_kicker: RTL and testbench

Host-side companion to `watchdog_timer`: turns keepalive events from the command processor into rate-limited `heartbeat` pulses and controls the watchdog's `enable`. If host keepalives stop for `HOST_TIMEOUT` cycles, it deliberately stops kicking so the watchdog fires. After a trip it stays latched until the host explicitly re-arms it. It sits between the SCPI/command decoder and `watchdog_timer` in the FPGA control path.

---
 rtl/wd_pkg.sv | 18 +
 rtl/hb_interval_timer.sv | 30 +++
 rtl/heartbeat_kicker.sv | 130 +++++++++++++
 tb/tb_heartbeat_kicker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wd_pkg.sv
// Shared definitions for the watchdog path: kicker state encoding and the
// width of the heartbeat counter.
package wd_pkg;

    localparam int KICK_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STARVED  = 2'd2,
        ST_TRIPPED  = 2'd3
    } wd_state_e;

    function automatic logic [KICK_CNT_W-1:0] sat_inc(input logic [KICK_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/hb_interval_timer.sv
// Loadable down-counter that holds at zero and flags it; used for both the
// heartbeat gap and the host-silence timeout.
module hb_interval_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         step,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (step && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/heartbeat_kicker.sv
// Turns host keepalives into rate-limited watchdog heartbeats, starves the
// watchdog on host silence and latches after a trip until re-armed.
module heartbeat_kicker
    import wd_pkg::*;
#(
    parameter int MIN_GAP      = 1000,
    parameter int HOST_TIMEOUT = 125_000_000,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_req,
    input  logic                  host_alive,
    input  logic                  rearm,
    input  logic                  wd_triggered,
    output logic                  heartbeat,
    output logic                  wd_enable,
    output wd_state_e             state,
    output logic                  pending,
    output logic [KICK_CNT_W-1:0] kick_count
);

    localparam logic [CNT_W-1:0] GAP_RELOAD     = CNT_W'(MIN_GAP - 1);
    // Silence timer hits zero on the cycle whose next state must be STARVED.
    localparam logic [CNT_W-1:0] SILENCE_RELOAD = CNT_W'(HOST_TIMEOUT - 2);

    wd_state_e        next_state;
    logic             next_pending;
    logic             kick;
    logic             gap_load;
    logic             gap_clear;
    logic             gap_zero;
    logic [CNT_W-1:0] gap_value;
    logic             silence_load;
    logic             silence_zero;

    assign gap_value = gap_clear ? '0 : GAP_RELOAD;

    hb_interval_timer #(.W(CNT_W)) u_gap (
        .clk        (clk),
        .rst        (rst),
        .load       (gap_load),
        .load_value (gap_value),
        .step       (1'b1),
        .zero       (gap_zero)
    );

    hb_interval_timer #(.W(CNT_W)) u_silence (
        .clk        (clk),
        .rst        (rst),
        .load       (silence_load),
        .load_value (SILENCE_RELOAD),
        .step       (state == ST_RUNNING),
        .zero       (silence_zero)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state   = state;
        next_pending = pending;
        kick         = 1'b0;
        gap_load     = 1'b0;
        gap_clear    = 1'b0;
        silence_load = 1'b0;

        case (state)
            ST_DISABLED: begin
                if (enable_req) begin
                    next_state   = ST_RUNNING;
                    next_pending = 1'b1;
                    gap_load     = 1'b1;
                    gap_clear    = 1'b1;
                    silence_load = 1'b1;
                end
            end
            ST_RUNNING, ST_STARVED: begin
                if (wd_triggered) begin
                    next_state   = ST_TRIPPED;
                    next_pending = 1'b0;
                end else if (!enable_req) begin
                    next_state   = ST_DISABLED;
                    next_pending = 1'b0;
                end else if (state == ST_STARVED) begin
                    if (host_alive) begin
                        next_state   = ST_RUNNING;
                        next_pending = 1'b1;
                        silence_load = 1'b1;
                    end
                end else begin
                    // A keepalive arriving while a pending kick fires is kept.
                    if ((pending || host_alive) && gap_zero) begin
                        kick         = 1'b1;
                        gap_load     = 1'b1;
                        next_pending = pending && host_alive;
                    end else begin
                        next_pending = pending || host_alive;
                    end
                    if (host_alive) begin
                        silence_load = 1'b1;
                    end else if (silence_zero) begin
                        next_state   = ST_STARVED;
                        next_pending = 1'b0;
                    end
                end
            end
            ST_TRIPPED: begin
                if (rearm) next_state = ST_DISABLED;
            end
            default: next_state = ST_DISABLED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_DISABLED;
            heartbeat  <= 1'b0;
            wd_enable  <= 1'b0;
            pending    <= 1'b0;
            kick_count <= '0;
        end else begin
            state     <= next_state;
            heartbeat <= kick;
            wd_enable <= (next_state != ST_DISABLED);
            pending   <= next_pending;
            if (kick) kick_count <= sat_inc(kick_count);
        end
    end

endmodule

// File: tb/tb_heartbeat_kicker.sv
// Bench for heartbeat_kicker: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_heartbeat_kicker;

    localparam int MIN_GAP      = 4;
    localparam int HOST_TIMEOUT = 10;
    localparam int KC_MAX       = 65535;

    logic        clk, rst, enable_req, host_alive, rearm, wd_triggered;
    logic        heartbeat, wd_enable, pending;
    logic [1:0]  state;
    logic [15:0] kick_count;

    logic        clk_s, rst_s, en_s, alive_s;
    logic        hb_s, wde_s, pend_s;
    logic [1:0]  st_s;
    logic [15:0] kc_s;

    int n_checks = 0;
    int n_errors = 0;
    int base     = 0;
    int pulses;
    int last_hb;

    heartbeat_kicker #(.MIN_GAP(MIN_GAP), .HOST_TIMEOUT(HOST_TIMEOUT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .enable_req(enable_req), .host_alive(host_alive),
        .rearm(rearm), .wd_triggered(wd_triggered), .heartbeat(heartbeat),
        .wd_enable(wd_enable), .state(state), .pending(pending), .kick_count(kick_count)
    );

    // Kicks every cycle, used only to reach kick_count saturation quickly.
    heartbeat_kicker #(.MIN_GAP(1), .HOST_TIMEOUT(10), .CNT_W(32)) sat_dut (
        .clk(clk_s), .rst(rst_s), .enable_req(en_s), .host_alive(alive_s),
        .rearm(1'b0), .wd_triggered(1'b0), .heartbeat(hb_s),
        .wd_enable(wde_s), .state(st_s), .pending(pend_s), .kick_count(kc_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial clk_s = 1'b0;
    always #1 clk_s = ~clk_s;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: gap and silence tracked as timestamps of the last kick
    // decision and the last keepalive rather than as counters.
    typedef struct {
        int st;
        bit pend;
        bit hb;
        int kc;
        int last_kick;
        int alive_ref;
        int cyc;
    } model_t;

    model_t m;

    function automatic model_t model_reset(model_t cur);
        model_t n;
        n = '{default: 0};
        n.cyc = cur.cyc;
        return n;
    endfunction

    function automatic model_t model_next(model_t cur, bit en, bit alive, bit trig, bit rearm_i);
        model_t n = cur;
        n.hb  = 1'b0;
        n.cyc = cur.cyc + 1;
        case (cur.st)
            0: if (en) begin
                n.st        = 1;
                n.pend      = 1'b1;
                n.last_kick = cur.cyc - MIN_GAP;
                n.alive_ref = cur.cyc;
            end
            1, 2: begin
                if (trig) begin
                    n.st = 3; n.pend = 1'b0;
                end else if (!en) begin
                    n.st = 0; n.pend = 1'b0;
                end else if (cur.st == 1) begin
                    if ((cur.pend || alive) && (cur.cyc - cur.last_kick >= MIN_GAP)) begin
                        n.hb        = 1'b1;
                        n.last_kick = cur.cyc;
                        n.pend      = cur.pend && alive;
                        n.kc        = (cur.kc == KC_MAX) ? KC_MAX : cur.kc + 1;
                    end else begin
                        n.pend = cur.pend || alive;
                    end
                    if (alive) n.alive_ref = cur.cyc;
                    else if (cur.cyc - cur.alive_ref >= HOST_TIMEOUT - 1) begin
                        n.st = 2; n.pend = 1'b0;
                    end
                end else if (alive) begin
                    n.st = 1; n.pend = 1'b1; n.alive_ref = cur.cyc;
                end
            end
            default: if (rearm_i) n.st = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset(m);
        else     m <= model_next(m, enable_req, host_alive, wd_triggered, rearm);
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("mdl_state",      int'(state),      m.st);
            check("mdl_heartbeat",  int'(heartbeat),  int'(m.hb));
            check("mdl_wd_enable",  int'(wd_enable),  int'(m.st != 0));
            check("mdl_pending",    int'(pending),    int'(m.pend));
            check("mdl_kick_count", int'(kick_count), m.kc);
        end
    end

    task automatic goto(input int n);
        while (m.cyc - base < n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: got no finish, expected finish before time limit");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        enable_req = 0; host_alive = 0; rearm = 0; wd_triggered = 0;
        en_s = 0; alive_s = 0;
        rst = 0; rst_s = 0;
        #1;
        rst = 1; rst_s = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_wd_enable", int'(wd_enable), 0);
        check("rst_heartbeat", int'(heartbeat), 0);
        check("rst_kick_count", int'(kick_count), 0);

        // Enable: wd_enable at 1, first heartbeat at 2
        base = m.cyc; enable_req = 1;
        goto(1);
        check("t1_wd_enable", int'(wd_enable), 1);
        check("t1_state", int'(state), 1);
        check("t1_hb_early", int'(heartbeat), 0);
        goto(2);
        check("t1_heartbeat", int'(heartbeat), 1);
        check("t1_kick_count", int'(kick_count), 1);

        // Keepalives while gap is nonzero collapse into one pending kick
        goto(3); host_alive = 1;
        goto(4); check("t3_pending_c4", int'(pending), 1);
        goto(5); host_alive = 0;
        check("t3_pending_c5", int'(pending), 1);
        check("t3_hb_c5", int'(heartbeat), 0);
        goto(6);
        check("t3_heartbeat", int'(heartbeat), 1);
        check("t3_kick_count", int'(kick_count), 2);
        check("t3_pending_cleared", int'(pending), 0);
        pulses = 0;
        for (int k = 7; k <= 11; k++) begin
            goto(k);
            pulses += int'(heartbeat);
        end
        check("t3_no_second", pulses, 0);

        // Keepalive every cycle for 20 cycles (12..31)
        pulses = 0; last_hb = -1;
        for (int k = 12; k <= 32; k++) begin
            goto(k);
            check("t2_state", int'(state), 1);
            if (k >= 13 && heartbeat) begin
                if (last_hb >= 0) check("t2_spacing", k - last_hb, MIN_GAP);
                last_hb = k;
                pulses++;
            end
            host_alive = (k <= 31);
        end
        check("t2_pulses", pulses, 5);
        goto(33);
        check("t2_pending_kick", int'(heartbeat), 1);
        check("t2_kick_count", int'(kick_count), 8);

        // Silence: last keepalive at 31 -> STARVED at 41; rearm ignored
        pulses = 0;
        for (int k = 34; k <= 44; k++) begin
            goto(k);
            pulses += int'(heartbeat);
            if (k == 35) rearm = 1;
            if (k == 36) begin
                rearm = 0;
                check("t4_rearm_ignored", int'(state), 1);
            end
            if (k == 40) check("t4_state_c40", int'(state), 1);
            if (k == 41) begin
                check("t4_starved", int'(state), 2);
                check("t4_wd_enable", int'(wd_enable), 1);
                check("t4_pending", int'(pending), 0);
            end
        end
        check("t4_no_hb", pulses, 0);
        goto(45); host_alive = 1;
        goto(46); host_alive = 0;
        check("t4_recovered", int'(state), 1);
        check("t4_recover_pending", int'(pending), 1);
        goto(47);
        check("t4_recover_hb", int'(heartbeat), 1);
        check("t4_kick_count", int'(kick_count), 9);

        // Trip coincides with a due kick; latched until rearm
        goto(50); host_alive = 1; wd_triggered = 1;
        goto(51); host_alive = 0;
        check("t5_tripped", int'(state), 3);
        check("t5_no_hb", int'(heartbeat), 0);
        check("t5_wd_enable", int'(wd_enable), 1);
        check("t5_kick_count", int'(kick_count), 9);
        for (int k = 52; k <= 56; k++) begin
            goto(k);
            check("t5_enable_ignored", int'(state), 3);
            enable_req = (k % 2 == 1);
        end
        goto(57); check("t5_still_tripped", int'(state), 3);
        enable_req = 1; rearm = 1;
        goto(58); rearm = 0; wd_triggered = 0;
        check("t5_rearm_state", int'(state), 0);
        check("t5_rearm_wd_enable", int'(wd_enable), 0);
        goto(59);
        check("t5_rerun", int'(state), 1);
        check("t5_rerun_pending", int'(pending), 1);
        enable_req = 0;
        goto(60);
        check("t5_disable_state", int'(state), 0);
        check("t5_disable_no_hb", int'(heartbeat), 0);
        check("t5_disable_pending", int'(pending), 0);

        // Async reset in the middle of the 7th heartbeat pulse
        @(negedge clk); rst = 1;
        @(negedge clk);
        check("t6_rst_clears_count", int'(kick_count), 0);
        rst = 0;
        @(negedge clk);
        base = m.cyc; enable_req = 1; host_alive = 1;
        goto(26);
        check("t6_hb_before_rst", int'(heartbeat), 1);
        check("t6_kc_before_rst", int'(kick_count), 7);
        #2 rst = 1;
        #1;
        check("t6_async_hb", int'(heartbeat), 0);
        check("t6_async_kc", int'(kick_count), 0);
        check("t6_async_wd_enable", int'(wd_enable), 0);
        check("t6_async_state", int'(state), 0);
        check("t6_async_pending", int'(pending), 0);
        enable_req = 0; host_alive = 0;
        @(negedge clk); rst = 0;

        // Saturation run: one kick per cycle, kick_count = cycle - 1
        @(negedge clk_s); rst_s = 0;
        @(negedge clk_s); en_s = 1; alive_s = 1;
        repeat (65535) @(negedge clk_s);
        check("sat_kc_fffe", int'(kc_s), 16'hFFFE);
        @(negedge clk_s);
        check("sat_kc_ffff", int'(kc_s), 16'hFFFF);
        repeat (4) @(negedge clk_s);
        check("sat_kc_held", int'(kc_s), 16'hFFFF);
        check("sat_hb_still", int'(hb_s), 1);
        check("sat_state", int'(st_s), 1);
        check("sat_wd_enable", int'(wde_s), 1);
        check("sat_pending", int'(pend_s), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
